// File: rtl/z80_bus_sequencer.sv
// Z80 bus-cycle sequencer: two requester ports arbitrated round-robin, each command
// replayed as a Z80 fetch/memory/IO machine cycle at half-T (H) resolution with /WAIT
// handling and an optional idle gap after every cycle.
module z80_bus_sequencer #(
  parameter int unsigned GAP = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic [2:0]  p0_op,
  input  logic [15:0] p0_addr,
  input  logic [7:0]  p0_wdata,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic [2:0]  p1_op,
  input  logic [15:0] p1_addr,
  input  logic [7:0]  p1_wdata,
  output logic        rsp_valid,
  output logic        rsp_port,
  output logic [7:0]  rsp_data,
  input  logic        wait_n,
  input  logic [7:0]  d_in,
  output logic        mreq_n,
  output logic        iorq_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic [15:0] a,
  output logic [7:0]  d_out,
  output logic        d_oe,
  output logic        busy
);

  localparam logic [2:0] OpFetch = 3'd0;
  localparam logic [2:0] OpMemRd = 3'd1;
  localparam logic [2:0] OpMemWr = 3'd2;
  localparam logic [2:0] OpIoRd  = 3'd3;
  localparam logic [2:0] OpIoWr  = 3'd4;

  localparam logic [3:0] GapM1 = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {StIdle, StRun, StWait, StGap} state_e;

  // Last H index of the machine cycle; illegal ops occupy only H0.
  function automatic logic [2:0] f_last(input logic [2:0] op);
    logic [2:0] r;
    r = 3'd0;
    case (op)
      OpFetch, OpIoRd, OpIoWr: r = 3'd7;
      OpMemRd, OpMemWr:        r = 3'd5;
      default:                 r = 3'd0;
    endcase
    return r;
  endfunction

  // H at whose end /WAIT is sampled.
  function automatic logic [2:0] f_wait_h(input logic [2:0] op);
    return (op == OpIoRd || op == OpIoWr) ? 3'd4 : 3'd2;
  endfunction

  function automatic logic f_legal(input logic [2:0] op);
    return op <= OpIoWr;
  endfunction

  function automatic logic f_is_read(input logic [2:0] op);
    return op == OpFetch || op == OpMemRd || op == OpIoRd;
  endfunction

  function automatic logic f_is_write(input logic [2:0] op);
    return op == OpMemWr || op == OpIoWr;
  endfunction

  // H at whose end read data is captured.
  function automatic logic [2:0] f_sample_h(input logic [2:0] op);
    logic [2:0] r;
    r = 3'd0;
    case (op)
      OpFetch: r = 3'd3;
      OpMemRd: r = 3'd4;
      OpIoRd:  r = 3'd6;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  // Active-high {mreq, iorq, rd, wr, oe} for a given op and H.
  function automatic logic [4:0] f_strobes(input logic [2:0] op, input logic [2:0] h);
    logic m, i, r, w, o;
    m = 1'b0; i = 1'b0; r = 1'b0; w = 1'b0; o = 1'b0;
    case (op)
      OpFetch: begin m = (h >= 3'd1) && (h <= 3'd3); r = m; end
      OpMemRd: begin m = (h >= 3'd1) && (h <= 3'd4); r = m; end
      OpMemWr: begin
        m = (h >= 3'd1) && (h <= 3'd4);
        w = (h >= 3'd3) && (h <= 3'd4);
        o = (h <= 3'd5);
      end
      OpIoRd:  begin i = (h >= 3'd2) && (h <= 3'd6); r = i; end
      OpIoWr:  begin i = (h >= 3'd2) && (h <= 3'd6); w = i; o = 1'b1; end
      default: ;
    endcase
    return {m, i, r, w, o};
  endfunction

  state_e      r_state, w_state_d;
  logic [2:0]  r_h, w_h_d;
  logic        r_tw, w_tw_d;
  logic [3:0]  r_gap, w_gap_d;
  logic        r_wait_ok;
  logic        r_last;
  logic [2:0]  r_op;
  logic        r_port;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic [4:0]  r_strb, w_strb_d;
  logic        r_rsp_valid;
  logic        r_rsp_port;
  logic [7:0]  r_rsp_data;

  logic        w_grant;
  logic        w_idle_ok;
  logic        w_accept;
  logic        w_done;
  logic [2:0]  w_op_in;
  logic [2:0]  w_op_n;

  // Round-robin grant: favour the port not granted last when both request.
  always_comb begin
    w_grant   = (p0_valid && p1_valid) ? ~r_last : p1_valid;
    w_idle_ok = rst_n && (r_state == StIdle);
    p0_ready  = w_idle_ok && p0_valid && !w_grant;
    p1_ready  = w_idle_ok && p1_valid && w_grant;
    w_accept  = p0_ready || p1_ready;
    w_op_in   = w_grant ? p1_op : p0_op;
    w_op_n    = w_accept ? w_op_in : r_op;
  end

  // Next-state logic of the cycle sequencer.
  always_comb begin
    w_state_d = r_state;
    w_h_d     = r_h;
    w_tw_d    = r_tw;
    w_gap_d   = r_gap;
    w_done    = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_d = StRun;
          w_h_d     = 3'd0;
        end
      end
      StRun: begin
        if (f_legal(r_op) && (r_h == f_wait_h(r_op)) && !wait_n) begin
          w_state_d = StWait;
          w_tw_d    = 1'b0;
        end else if (r_h == f_last(r_op)) begin
          w_done = 1'b1;
          if (GAP > 0) begin
            w_state_d = StGap;
            w_gap_d   = GapM1;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_h_d = r_h + 3'd1;
        end
      end
      StWait: begin
        // Tw pairs: /WAIT captured at the end of the first, decision taken after the second.
        if (!r_tw) begin
          w_tw_d = 1'b1;
        end else if (r_wait_ok) begin
          w_state_d = StRun;
          w_h_d     = f_wait_h(r_op) + 3'd1;
        end else begin
          w_tw_d = 1'b0;
        end
      end
      StGap: begin
        if (r_gap == 4'd0) w_state_d = StIdle;
        else               w_gap_d   = r_gap - 4'd1;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Strobes are decoded from the next state and registered; frozen during wait states.
  always_comb begin
    w_strb_d = 5'b0;
    if (w_state_d == StWait)     w_strb_d = r_strb;
    else if (w_state_d == StRun) w_strb_d = f_strobes(w_op_n, w_h_d);
  end

  // State register and sequencing counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_h       <= 3'd0;
      r_tw      <= 1'b0;
      r_gap     <= 4'd0;
      r_wait_ok <= 1'b0;
      r_last    <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_h     <= w_h_d;
      r_tw    <= w_tw_d;
      r_gap   <= w_gap_d;
      if (r_state == StWait && !r_tw) r_wait_ok <= wait_n;
      if (w_accept) r_last <= w_grant;
    end
  end

  // Command capture, read-data capture, bus strobes and completion response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op        <= 3'd0;
      r_port      <= 1'b0;
      r_addr      <= 16'd0;
      r_wdata     <= 8'd0;
      r_rdata     <= 8'd0;
      r_strb      <= 5'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_port  <= 1'b0;
      r_rsp_data  <= 8'd0;
    end else begin
      if (w_accept) begin
        r_op    <= w_op_in;
        r_port  <= w_grant;
        r_addr  <= w_grant ? p1_addr : p0_addr;
        r_wdata <= w_grant ? p1_wdata : p0_wdata;
      end
      if (r_state == StRun && f_is_read(r_op) && r_h == f_sample_h(r_op)) r_rdata <= d_in;
      r_strb      <= w_strb_d;
      r_rsp_valid <= w_done;
      if (w_done) begin
        r_rsp_port <= r_port;
        if (f_is_read(r_op))       r_rsp_data <= r_rdata;
        else if (f_is_write(r_op)) r_rsp_data <= 8'h00;
        else                       r_rsp_data <= 8'hFF;
      end
    end
  end

  assign mreq_n    = ~r_strb[4];
  assign iorq_n    = ~r_strb[3];
  assign rd_n      = ~r_strb[2];
  assign wr_n      = ~r_strb[1];
  assign d_oe      = r_strb[0];
  assign a         = r_addr;
  assign d_out     = r_wdata;
  assign busy      = (r_state != StIdle);
  assign rsp_valid = r_rsp_valid;
  assign rsp_port  = r_rsp_port;
  assign rsp_data  = r_rsp_data;

endmodule
